// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt vector controller.
// Holds the sequencing state enum, register map, EOI/spurious constants,
// the configuration-port request payload and a one-hot helper.
package irq_pkg;

    localparam int unsigned NUM_IRQ = 8;
    localparam int unsigned IID_W   = 3;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned VEC_W   = 10;

    localparam logic [ADDR_W-1:0] ADDR_IMR     = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_ISR_EOI = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_VBASE   = 2'd2;

    localparam int unsigned       EOI_NS_BIT = 7;
    localparam logic [IID_W-1:0]  SPUR_IID   = 3'd7;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACK1 = 3'd1,
        ACK2 = 3'd2,
        DROP = 3'd3,
        VEC  = 3'd4
    } irq_state_e;

    // One configuration-port access as seen in a single cycle.
    typedef struct packed {
        logic              cs;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } io_req_t;

    function automatic logic [NUM_IRQ-1:0] iid_onehot(input logic [IID_W-1:0] iid);
        return NUM_IRQ'(1) << iid;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-set-bit encoder: bit 0 is the highest priority.
// Ports:
//   i_bits    - request/in-service bit vector
//   o_idx_c   - index of the lowest set bit (0 when none set)
//   o_none_c  - no bit set
module irq_prio_enc
    import irq_pkg::*;
(
    input  logic [NUM_IRQ-1:0] i_bits,
    output logic [IID_W-1:0]   o_idx_c,
    output logic               o_none_c
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        o_idx_c  = '0;
        o_none_c = 1'b1;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (i_bits[i]) begin
                o_idx_c  = IID_W'(i);
                o_none_c = 1'b0;
            end
        end
    end

endmodule

// File: rtl/irq_vector_ctrl.sv
// Interrupt sequencing between the 8-input priority controller and the CPU.
// Masks raw IRQs, tracks in-service levels, runs the two-cycle acknowledge
// on pic_inta plus the release cycle, then hands a vector table address to
// the CPU over valid/ready.
// Ports:
//   clk, rst                - clock, asynchronous active-low reset
//   irq_raw / irq_gated     - raw lines in, masked lines to controller intv
//   pic_intr, pic_iid       - controller request and interrupt ID
//   pic_inta                - acknowledge to controller (registered)
//   cpu_intr, cpu_ack       - request to CPU (combinational), CPU accept pulse
//   vec_valid/addr/ready    - vector delivery handshake
//   io_cs/we/addr/wdata/rdata - configuration port (IMR, ISR/EOI, vector base)
module irq_vector_ctrl
    import irq_pkg::*;
#(
    parameter logic [DATA_W-1:0] VEC_BASE_RST = 8'h08
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_raw,
    output logic [NUM_IRQ-1:0] irq_gated,
    input  logic               pic_intr,
    input  logic [IID_W-1:0]   pic_iid,
    output logic               pic_inta,
    output logic               cpu_intr,
    input  logic               cpu_ack,
    output logic               vec_valid,
    output logic [VEC_W-1:0]   vec_addr,
    input  logic               vec_ready,
    input  logic               io_cs,
    input  logic               io_we,
    input  logic [ADDR_W-1:0]  io_addr,
    input  logic [DATA_W-1:0]  io_wdata,
    output logic [DATA_W-1:0]  io_rdata
);

    localparam logic [DATA_W-1:0] VBASE_RST = {VEC_BASE_RST[DATA_W-1:3], 3'b000};

    irq_state_e          r_state;
    logic [NUM_IRQ-1:0]  r_imr;
    logic [NUM_IRQ-1:0]  r_isr;
    logic [DATA_W-1:0]   r_vbase;
    logic [IID_W-1:0]    r_cur_iid;
    logic                r_spur;

    io_req_t             w_io_req;
    logic                w_wr;
    logic                w_rd;
    logic [IID_W-1:0]    w_isr_idx;
    logic                w_isr_none;
    logic                w_allowed;
    logic [NUM_IRQ-1:0]  w_eoi_clr;
    logic [NUM_IRQ-1:0]  w_ack_set;
    logic [IID_W-1:0]    w_vec_iid;
    logic [DATA_W-1:0]   w_vec_sum;

    assign w_io_req = '{cs: io_cs, we: io_we, addr: io_addr, wdata: io_wdata};
    assign w_wr     = w_io_req.cs &  w_io_req.we;
    assign w_rd     = w_io_req.cs & ~w_io_req.we;

    assign irq_gated = irq_raw & ~r_imr;

    // Highest in-service level, shared by the nesting gate and non-specific EOI.
    irq_prio_enc u_isr_enc (
        .i_bits   (r_isr),
        .o_idx_c  (w_isr_idx),
        .o_none_c (w_isr_none)
    );

    // Only strictly higher priorities than the current in-service level may nest.
    assign w_allowed = w_isr_none || (pic_iid < w_isr_idx);
    assign cpu_intr  = (r_state == IDLE) && pic_intr && w_allowed;

    // EOI decode: bit 7 selects non-specific (retire highest in-service level).
    always_comb begin
        w_eoi_clr = '0;
        if (w_wr && (w_io_req.addr == ADDR_ISR_EOI)) begin
            if (w_io_req.wdata[EOI_NS_BIT]) begin
                if (!w_isr_none) begin
                    w_eoi_clr = iid_onehot(w_isr_idx);
                end
            end else begin
                w_eoi_clr = iid_onehot(w_io_req.wdata[IID_W-1:0]);
            end
        end
    end

    // A request withdrawn by ACK2 is spurious and does not enter service.
    assign w_ack_set = ((r_state == ACK2) && pic_intr) ? iid_onehot(pic_iid) : '0;

    assign w_vec_iid = r_spur ? SPUR_IID : r_cur_iid;
    assign w_vec_sum = r_vbase + DATA_W'(w_vec_iid);

    // Acknowledge / delivery sequencer with registered pic_inta and vector outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            pic_inta  <= 1'b0;
            vec_valid <= 1'b0;
            vec_addr  <= '0;
            r_cur_iid <= '0;
            r_spur    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cpu_ack && cpu_intr) begin
                        pic_inta <= 1'b1;
                        r_state  <= ACK1;
                    end
                end
                ACK1: begin
                    r_state <= ACK2;
                end
                ACK2: begin
                    r_cur_iid <= pic_iid;
                    r_spur    <= ~pic_intr;
                    pic_inta  <= 1'b0;
                    r_state   <= DROP;
                end
                DROP: begin
                    // Address latched here so later base writes leave it intact.
                    vec_addr  <= {w_vec_sum, 2'b00};
                    vec_valid <= 1'b1;
                    r_state   <= VEC;
                end
                VEC: begin
                    if (vec_ready) begin
                        vec_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    pic_inta  <= 1'b0;
                    vec_valid <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    // Configuration registers, in-service tracking and registered read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_imr    <= '1;
            r_isr    <= '0;
            r_vbase  <= VBASE_RST;
            io_rdata <= '0;
        end else begin
            if (w_wr && (w_io_req.addr == ADDR_IMR)) begin
                r_imr <= w_io_req.wdata;
            end
            if (w_wr && (w_io_req.addr == ADDR_VBASE)) begin
                r_vbase <= {w_io_req.wdata[DATA_W-1:3], 3'b000};
            end
            // Set after clear so an acknowledge beats a same-cycle EOI.
            r_isr <= (r_isr & ~w_eoi_clr) | w_ack_set;
            if (w_rd) begin
                case (w_io_req.addr)
                    ADDR_IMR:     io_rdata <= r_imr;
                    ADDR_ISR_EOI: io_rdata <= r_isr;
                    ADDR_VBASE:   io_rdata <= r_vbase;
                    default:      io_rdata <= '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Bench for irq_vector_ctrl: models the priority controller, drives directed
// and random interrupt traffic, and checks delivered vectors via a scoreboard.
module tb_irq_vector_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] irq_raw = 8'h00;
    logic [7:0] irq_gated;
    logic       pic_intr;
    logic [2:0] pic_iid;
    logic       pic_inta;
    logic       cpu_intr;
    logic       cpu_ack = 1'b0;
    logic       vec_valid;
    logic [9:0] vec_addr;
    logic       vec_ready = 1'b0;
    logic       io_cs = 1'b0;
    logic       io_we = 1'b0;
    logic [1:0] io_addr = 2'd0;
    logic [7:0] io_wdata = 8'h00;
    logic [7:0] io_rdata;

    int total = 0;
    int bad   = 0;

    // Reference state
    logic [7:0] m_isr   = 8'h00;
    logic [7:0] m_imr   = 8'hFF;
    logic [7:0] m_vbase = 8'h08;
    logic [9:0] exp_q[$];
    int         ready_mode = 0;   // 0 always ready, 1 random, 3 manual

    always #5 clk = ~clk;

    irq_vector_ctrl #(.VEC_BASE_RST(8'h08)) dut (
        .clk(clk), .rst(rst),
        .irq_raw(irq_raw), .irq_gated(irq_gated),
        .pic_intr(pic_intr), .pic_iid(pic_iid), .pic_inta(pic_inta),
        .cpu_intr(cpu_intr), .cpu_ack(cpu_ack),
        .vec_valid(vec_valid), .vec_addr(vec_addr), .vec_ready(vec_ready),
        .io_cs(io_cs), .io_we(io_we), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_rdata(io_rdata)
    );

    // ---------------- external priority controller model ----------------
    logic [7:0] pic_pend, pic_gq;
    logic       pic_inta_q, pic_frz, pic_kill = 1'b0;
    logic [2:0] pic_frozen;

    function automatic logic [2:0] low_idx(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) if (v[i]) r = 3'(i);
        return r;
    endfunction

    assign pic_iid  = pic_frz ? pic_frozen : low_idx(pic_pend);
    assign pic_intr = (|pic_pend) & ~pic_kill;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pic_pend <= 8'h00; pic_gq <= 8'h00; pic_inta_q <= 1'b0;
            pic_frz <= 1'b0; pic_frozen <= 3'd0;
        end else begin
            pic_gq     <= irq_gated;
            pic_inta_q <= pic_inta;
            if (pic_inta && !pic_inta_q) begin
                pic_frz    <= 1'b1;
                pic_frozen <= low_idx(pic_pend);
            end
            if (pic_inta_q && !pic_inta) begin
                pic_frz  <= 1'b0;
                pic_pend <= (pic_pend & ~(8'd1 << pic_frozen)) | (irq_gated & ~pic_gq);
            end else begin
                pic_pend <= pic_pend | (irq_gated & ~pic_gq);
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] exp_vec(input int iid);
        int s;
        s = (int'(m_vbase) + iid) % 256;
        return 10'(s * 4);
    endfunction

    // Allowed iff no in-service level at or above this priority.
    function automatic logic ref_allowed(input int iid);
        return (int'(m_isr) & ((2 << iid) - 1)) == 0;
    endfunction

    // vec_ready driver
    initial begin
        forever begin
            @(posedge clk); #1;
            if (ready_mode == 0) vec_ready = 1'b1;
            else if (ready_mode == 1) vec_ready = 1'($urandom_range(0, 1));
        end
    end

    // Scoreboard monitor: pops on every accepted vector, checks hold stability.
    initial begin
        logic       pv;
        logic [9:0] pa;
        pv = 1'b0; pa = 10'd0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pv = 1'b0;
            end else begin
                if (pv && vec_valid) chk("vec_addr_stable", 32'(vec_addr), 32'(pa));
                if (vec_valid && vec_ready) begin
                    if (exp_q.size() == 0) chk("vec_queue_nonempty", 32'(exp_q.size()), 32'd1);
                    else chk("vec_addr", 32'(vec_addr), 32'(exp_q.pop_front()));
                end
                pv = vec_valid;
                pa = vec_addr;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic io_write(input logic [1:0] a, input logic [7:0] d);
        io_cs = 1'b1; io_we = 1'b1; io_addr = a; io_wdata = d;
        tick();
        io_cs = 1'b0; io_we = 1'b0;
    endtask

    task automatic io_read_chk(input string name, input logic [1:0] a, input logic [7:0] exp);
        io_cs = 1'b1; io_we = 1'b0; io_addr = a;
        tick();
        io_cs = 1'b0;
        chk(name, 32'(io_rdata), 32'(exp));
    endtask

    task automatic set_imr(input logic [7:0] d);
        io_write(2'd0, d); m_imr = d;
    endtask

    task automatic set_vbase(input logic [7:0] d);
        io_write(2'd2, d); m_vbase = d & 8'hF8;
    endtask

    task automatic eoi_ns();
        io_write(2'd1, 8'h80); m_isr = m_isr & (m_isr - 8'd1);
    endtask

    task automatic eoi_spec(input int n);
        io_write(2'd1, 8'(n)); m_isr[3'(n)] = 1'b0;
    endtask

    task automatic raise(input int iid);
        irq_raw[3'(iid)] = 1'b1;
        set_imr(8'(~(8'd1 << iid)));
        tick(); tick();
    endtask

    task automatic lower(input int iid);
        irq_raw[3'(iid)] = 1'b0;
        set_imr(8'hFF);
    endtask

    // mode 0 normal, 1 specific EOI of same bit during ACK2, 2 spurious
    task automatic do_ack(input int iid, input int mode);
        exp_q.push_back(mode == 2 ? exp_vec(7) : exp_vec(iid));
        if (mode != 2) m_isr[3'(iid)] = 1'b1;
        cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
        chk("inta_ack1", 32'(pic_inta), 32'd1);
        chk("valid_ack1", 32'(vec_valid), 32'd0);
        tick();
        chk("inta_ack2", 32'(pic_inta), 32'd1);
        chk("cpu_intr_busy", 32'(cpu_intr), 32'd0);
        if (mode == 1) begin
            io_cs = 1'b1; io_we = 1'b1; io_addr = 2'd1; io_wdata = 8'(iid);
        end
        if (mode == 2) pic_kill = 1'b1;
        tick();
        io_cs = 1'b0; io_we = 1'b0; pic_kill = 1'b0;
        chk("inta_drop", 32'(pic_inta), 32'd0);
        chk("valid_drop", 32'(vec_valid), 32'd0);
        tick();
        chk("valid_latency", 32'(vec_valid), 32'd1);
    endtask

    task automatic wait_vec_done();
        int n;
        n = 0;
        while (vec_valid && n < 64) begin tick(); n++; end
        chk("vec_done_in_time", 32'(vec_valid), 32'd0);
    endtask

    task automatic serve(input int iid, input int mode);
        raise(iid);
        chk("cpu_intr_gate", 32'(cpu_intr), 32'(ref_allowed(iid)));
        while (!ref_allowed(iid)) eoi_ns();
        chk("cpu_intr_req", 32'(cpu_intr), 32'd1);
        do_ack(iid, mode);
        wait_vec_done();
        lower(iid);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic seen;
        irq_raw = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_inta", 32'(pic_inta), 32'd0);
        chk("rst_cpu_intr", 32'(cpu_intr), 32'd0);
        chk("rst_vec_valid", 32'(vec_valid), 32'd0);
        chk("rst_vec_addr", 32'(vec_addr), 32'd0);
        chk("rst_rdata", 32'(io_rdata), 32'd0);
        chk("rst_gated", 32'(irq_gated), 32'd0);
        rst = 1'b1;
        irq_raw = 8'h00;
        tick();
        io_read_chk("imr_rst", 2'd0, 8'hFF);
        io_read_chk("isr_rst", 2'd1, 8'h00);
        io_read_chk("vbase_rst", 2'd2, 8'h08);
        io_write(2'd3, 8'h5A);
        io_read_chk("addr3_zero", 2'd3, 8'h00);

        // Basic acknowledge of IRQ4 with IMR=EF
        ready_mode = 0;
        serve(4, 0);
        io_read_chk("isr_after_4", 2'd1, m_isr);

        // Nested higher priority
        serve(1, 0);
        io_read_chk("isr_nested", 2'd1, m_isr);
        eoi_spec(1);
        io_read_chk("isr_eoi1", 2'd1, m_isr);

        // Lower priority held off until non-specific EOI
        serve(6, 0);
        io_read_chk("isr_after_6", 2'd1, m_isr);
        eoi_spec(6);

        // Stalled delivery with base 0x70, IRQ3
        set_vbase(8'h70);
        io_read_chk("vbase_70", 2'd2, m_vbase);
        ready_mode = 3; vec_ready = 1'b0;
        raise(3);
        chk("cpu_intr_3", 32'(cpu_intr), 32'd1);
        do_ack(3, 0);
        repeat (5) begin
            tick();
            chk("held_valid", 32'(vec_valid), 32'd1);
            chk("held_addr", 32'(vec_addr), 32'h1CC);
        end
        vec_ready = 1'b1;
        tick();
        chk("idle_after_ready", 32'(vec_valid), 32'd0);
        vec_ready = 1'b0;
        ready_mode = 0;
        lower(3);

        // Same-cycle EOI of bit 2 while ACK2 sets it
        serve(2, 1);
        io_read_chk("isr_set_wins", 2'd1, m_isr);
        eoi_ns(); eoi_ns();
        io_read_chk("isr_cleared", 2'd1, m_isr);

        // Spurious acknowledge
        serve(5, 2);
        io_read_chk("isr_spur", 2'd1, m_isr);

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            int iid;
            iid = int'($urandom_range(0, 7));
            ready_mode = int'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) set_vbase(8'($urandom));
            if ($urandom_range(0, 3) == 0) eoi_spec(int'($urandom_range(0, 7)));
            serve(iid, 0);
            if ($urandom_range(0, 2) == 0) io_read_chk("isr_rand", 2'd1, m_isr);
            if ($urandom_range(0, 4) == 0) io_read_chk("vbase_rand", 2'd2, m_vbase);
        end

        // Reset in the middle of ACK2
        ready_mode = 0;
        while (m_isr != 8'h00) eoi_ns();
        serve(2, 0);
        irq_raw[0] = 1'b1;
        set_imr(8'hFE);
        tick(); tick();
        chk("cpu_intr_pre_rst", 32'(cpu_intr), 32'd1);
        cpu_ack = 1'b1; tick(); cpu_ack = 1'b0;
        tick();
        chk("inta_pre_rst", 32'(pic_inta), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("inta_in_rst", 32'(pic_inta), 32'd0);
        chk("valid_in_rst", 32'(vec_valid), 32'd0);
        irq_raw = 8'h00;
        m_isr = 8'h00; m_imr = 8'hFF; m_vbase = 8'h08;
        tick();
        rst = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            tick();
            if (vec_valid) seen = 1'b1;
        end
        chk("no_vec_after_rst", 32'(seen), 32'd0);
        io_read_chk("isr_post_rst", 2'd1, m_isr);
        io_read_chk("imr_post_rst", 2'd0, m_imr);
        io_read_chk("vbase_post_rst", 2'd2, m_vbase);

        tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
